// File: rtl/rr_req_arbiter_if.sv
// Handshake bundle between the requesters/resource side and the round-robin arbiter.
// The requester side drives the requests, flush and resource-ready.
// The arbiter drives the registered grant outputs.
interface rr_req_arbiter_if #(
    parameter int REQ_NUM = 4
) ();
    localparam int INDEX_W = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0] req;
    logic               flush;
    logic               grant_valid;
    logic [REQ_NUM-1:0] grant;
    logic [INDEX_W-1:0] grant_index;
    logic               grant_ready;

    modport master (
        output req,
        output flush,
        output grant_ready,
        input  grant_valid,
        input  grant,
        input  grant_index
    );

    modport slave (
        input  req,
        input  flush,
        input  grant_ready,
        output grant_valid,
        output grant,
        output grant_index
    );
endinterface

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter that shares one resource port among REQ_NUM requesters.
// The grant is registered and held stable until a handshake, a withdrawal or a flush.
// On a handshake the next winner is registered in the same cycle, so there is no bubble.
// Priority rotates to the entry after the last served requester.
module rr_req_arbiter #(
    parameter int REQ_NUM = 4
) (
    input logic        clk,
    input logic        rst,
    rr_req_arbiter_if.slave bus
);
    localparam int INDEX_W = $clog2(REQ_NUM);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_reg;
    logic [INDEX_W-1:0] ptr_reg;
    logic [INDEX_W-1:0] grant_index_reg;
    logic [REQ_NUM-1:0] grant_reg;
    logic               grant_valid_reg;

    logic [REQ_NUM-1:0] arb_req;
    logic [INDEX_W-1:0] arb_ptr;
    logic [INDEX_W-1:0] scan_idx;
    logic [INDEX_W-1:0] win_index;
    logic               win_found;
    logic [REQ_NUM-1:0] win_onehot;
    logic               req_held;

    // Select the arbitration inputs.
    // In GRANT the only arbitration that matters is the back-to-back one after a handshake.
    // It masks the served bit and scans from the entry after the served index.
    always_comb begin
        arb_req = bus.req;
        arb_ptr = ptr_reg;
        if (state_reg == GRANT) begin
            arb_req = bus.req & ~grant_reg;
            arb_ptr = grant_index_reg + INDEX_W'(1);
        end
    end

    // Scan the requests from arb_ptr upward with natural wrap; the first set bit wins.
    // Iterating from the farthest offset down lets the nearest set bit overwrite the others.
    always_comb begin
        win_found = 1'b0;
        win_index = '0;
        scan_idx  = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            scan_idx = arb_ptr + INDEX_W'(k);
            if (arb_req[scan_idx]) begin
                win_found = 1'b1;
                win_index = scan_idx;
            end
        end
    end

    // One-hot decode of the winning index.
    generate
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_index == INDEX_W'(gi));
        end
    endgenerate

    assign req_held = bus.req[grant_index_reg];

    // FSM, priority pointer and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            grant_valid_reg <= 1'b0;
            grant_reg       <= '0;
            grant_index_reg <= '0;
        end else if (bus.flush) begin
            // Flush wins over a simultaneous handshake.
            // The pointer is left alone, and no new grant is issued in this cycle.
            state_reg       <= IDLE;
            grant_valid_reg <= 1'b0;
            grant_reg       <= '0;
            grant_index_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg       <= GRANT;
                        grant_valid_reg <= 1'b1;
                        grant_reg       <= win_onehot;
                        grant_index_reg <= win_index;
                    end
                end
                GRANT: begin
                    if (bus.grant_ready) begin
                        // Accepted, even if the requester withdrew in this same cycle.
                        ptr_reg <= grant_index_reg + INDEX_W'(1);
                        if (win_found) begin
                            grant_reg       <= win_onehot;
                            grant_index_reg <= win_index;
                        end else begin
                            state_reg       <= IDLE;
                            grant_valid_reg <= 1'b0;
                            grant_reg       <= '0;
                            grant_index_reg <= '0;
                        end
                    end else if (!req_held) begin
                        // The requester gave up before service; drop the grant and keep the pointer.
                        state_reg       <= IDLE;
                        grant_valid_reg <= 1'b0;
                        grant_reg       <= '0;
                        grant_index_reg <= '0;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    grant_valid_reg <= 1'b0;
                    grant_reg       <= '0;
                    grant_index_reg <= '0;
                end
            endcase
        end
    end

    assign bus.grant_valid = grant_valid_reg;
    assign bus.grant       = grant_reg;
    assign bus.grant_index = grant_index_reg;

endmodule
